// File: rtl/keypad_guess_collector.sv
// Keypad front end: synchronizes and debounces ten digit buttons, then packs four presses into a BCD guess offered over valid/ready.
// Optional macro KEYPAD_DUP_REJECT_EN: drop presses whose digit is already in the partial guess.
module keypad_guess_collector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  key,
  input  logic        clear,
  output logic [15:0] guess,
  output logic        guess_valid,
  input  logic        guess_ready,
  output logic [2:0]  digit_count,
  output logic        key_event,
  output logic [3:0]  key_digit
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {COLLECT, OFFER} state_t;

  logic [9:0]       sync1_reg, sync2_reg, cand_prev_reg;
  logic [9:0]       stable_reg, stable_prev_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             key_event_reg;
  logic [3:0]       key_digit_reg;
  logic             press;
  logic             press_onehot;
  logic [3:0]       press_digit;
  logic             dup;
  logic [1:0]       slot;
  state_t           state_reg, state_next;
  logic [15:0]      guess_reg, guess_next;
  logic [2:0]       count_reg, count_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (sync2_reg != cand_prev_reg) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg       <= '0;
      sync2_reg       <= '0;
      cand_prev_reg   <= '0;
      cnt_reg         <= '0;
      stable_reg      <= '0;
      stable_prev_reg <= '0;
    end else begin
      sync1_reg       <= key;
      sync2_reg       <= sync1_reg;
      cand_prev_reg   <= sync2_reg;
      cnt_reg         <= cnt_next;
      stable_prev_reg <= stable_reg;
      if (cnt_next == CNT_MAX) begin
        stable_reg <= sync2_reg;
      end
    end
  end

  // A press is the debounced vector leaving all-zero for a single key; chords never qualify.
  always_comb begin
    press_onehot = (stable_reg != '0) && ((stable_reg & (stable_reg - 10'd1)) == '0);
    press        = press_onehot && (stable_prev_reg == '0);
    press_digit  = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (stable_reg[i]) begin
        press_digit = 4'(i);
      end
    end
  end

`ifdef KEYPAD_DUP_REJECT_EN
  // Unfilled slots hold 4'hF, which never equals a digit, so all four nibbles can be compared.
  logic [3:0] dup_hit;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dup
      assign dup_hit[gi] = (guess_reg[gi*4 +: 4] == press_digit);
    end
  endgenerate
  assign dup = |dup_hit;
`else
  assign dup = 1'b0;
`endif

  assign slot = 2'd3 - count_reg[1:0];

  always_comb begin
    state_next = state_reg;
    guess_next = guess_reg;
    count_next = count_reg;
    case (state_reg)
      COLLECT: begin
        if (clear) begin
          guess_next = 16'hFFFF;
          count_next = 3'd0;
        end else if (press && !dup) begin
          guess_next[{slot, 2'b00} +: 4] = press_digit;
          count_next = count_reg + 3'd1;
          if (count_reg == 3'd3) begin
            state_next = OFFER;
          end
        end
      end
      OFFER: begin
        if (guess_ready) begin
          state_next = COLLECT;
          guess_next = 16'hFFFF;
          count_next = 3'd0;
        end
      end
      default: begin
        state_next = COLLECT;
        guess_next = 16'hFFFF;
        count_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= COLLECT;
      guess_reg     <= 16'hFFFF;
      count_reg     <= 3'd0;
      key_event_reg <= 1'b0;
      key_digit_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      guess_reg     <= guess_next;
      count_reg     <= count_next;
      key_event_reg <= press;
      if (press) begin
        key_digit_reg <= press_digit;
      end
    end
  end

  assign guess       = guess_reg;
  assign guess_valid = (state_reg == OFFER);
  assign digit_count = count_reg;
  assign key_event   = key_event_reg;
  assign key_digit   = key_digit_reg;

endmodule

// File: tb/tb_keypad_guess_collector.sv
// Bench for keypad_guess_collector: window-based debounce model plus digit queue, checked every cycle, with directed scenarios.
module tb_keypad_guess_collector;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  key = '0;
  logic        clear = 1'b0;
  logic        guess_ready = 1'b0;
  logic [15:0] guess;
  logic        guess_valid;
  logic [2:0]  digit_count;
  logic        key_event;
  logic [3:0]  key_digit;

  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;
  int ev_cnt = 0;
  int vcyc = 0;
  logic [15:0] offered = 16'h0;

  always #5 clk = ~clk;

  keypad_guess_collector #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .key(key), .clear(clear),
    .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
    .digit_count(digit_count), .key_event(key_event), .key_digit(key_digit)
  );

  // Model: a raw vector is accepted once the last D synchronized samples agree.
  logic [9:0] hist [0:D+1];
  logic [9:0] m_st, m_st_old;
  int q[$];
  bit m_offer, m_ev, ev_now, same, dup_now;
  int m_digit, d_now;

  function automatic int idx_of(input logic [9:0] v);
    int r = 0;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [15:0] m_guess();
    logic [15:0] g = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) g[15-4*i -: 4] = 4'(q[i]);
    return g;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j <= D+1; j++) hist[j] = '0;
      m_st = '0; m_st_old = '0; q.delete();
      m_offer = 0; m_ev = 0; m_digit = 0;
    end else begin
      ev_now = ($countones(m_st) == 1) && (m_st_old == '0);
      d_now = idx_of(m_st);
      dup_now = 0;
`ifdef KEYPAD_DUP_REJECT_EN
      foreach (q[k]) if (q[k] == d_now) dup_now = 1;
`endif
      if (m_offer) begin
        if (guess_ready) begin m_offer = 0; q.delete(); end
      end else if (clear) begin
        q.delete();
      end else if (ev_now) begin
        if (!dup_now) q.push_back(d_now);
        if (q.size() == 4) m_offer = 1;
      end
      if (ev_now) m_digit = d_now;
      m_ev = ev_now;
      for (int j = D+1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key;
      same = 1;
      for (int j = 3; j <= D+1; j++) if (hist[j] != hist[2]) same = 0;
      m_st_old = m_st;
      if (same) m_st = hist[2];
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    while (!done) begin
      @(posedge clk); #1;
      if (!done) begin
        chk("guess", guess, m_guess());
        chk("guess_valid", 16'(guess_valid), 16'(m_offer));
        chk("digit_count", 16'(digit_count), 16'(q.size()));
        chk("key_event", 16'(key_event), 16'(m_ev));
        chk("key_digit", 16'(key_digit), 16'(m_digit));
        if (key_event) ev_cnt++;
        if (guess_valid) begin vcyc++; offered = guess; end
      end
    end
  end

  task automatic press_key(input int d, input int hold = 20, input int rel = 20);
    @(negedge clk) key = 10'd1 << d;
    repeat (hold) @(negedge clk);
    key = '0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_guess", guess, 16'hFFFF);
    chk("rst_valid", 16'(guess_valid), 16'd0);
    chk("rst_count", 16'(digit_count), 16'd0);
    chk("rst_event", 16'(key_event), 16'd0);
    chk("rst_digit", 16'(key_digit), 16'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1,2,3,4 with ready high: one-cycle offer
    guess_ready = 1'b1; vcyc = 0;
    press_key(1); press_key(2); press_key(3); press_key(4);
    chk("s1_offered", offered, 16'h1234);
    chk("s1_valid_cycles", 16'(vcyc), 16'd1);
    chk("s1_guess_after", guess, 16'hFFFF);
    chk("s1_count_after", 16'(digit_count), 16'd0);

    // bouncing key 5
    guess_ready = 1'b0; ev_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) key = (i % 2 == 0) ? 10'b00_0010_0000 : 10'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk) key = 10'b00_0010_0000;
    repeat (10) @(posedge clk);
    #1 chk("s2_no_early_event", 16'(key_event), 16'd0);
    @(posedge clk);
    #1 chk("s2_event_at_11", 16'(key_event), 16'd1);
    repeat (9) @(negedge clk);
    key = '0;
    repeat (20) @(negedge clk);
    chk("s2_event_count", 16'(ev_cnt), 16'd1);
    chk("s2_key_digit", 16'(key_digit), 16'd5);
    pulse_clear();

    // 9,8,7,6 held in offer while 0 is pressed
    ev_cnt = 0;
    press_key(9); press_key(8); press_key(7); press_key(6);
    press_key(0); repeat (10) @(negedge clk);
    chk("s3_guess_held", guess, 16'h9876);
    chk("s3_valid_held", 16'(guess_valid), 16'd1);
    chk("s3_key_digit", 16'(key_digit), 16'd0);
    chk("s3_event_count", 16'(ev_cnt), 16'd5);
    chk("s3_count_held", 16'(digit_count), 16'd4);
    @(negedge clk) guess_ready = 1'b1;
    @(posedge clk);
    #1 chk("s3_valid_drop", 16'(guess_valid), 16'd0);
    chk("s3_guess_reset", guess, 16'hFFFF);
    @(negedge clk) guess_ready = 1'b0;

    // clear during entry
    press_key(4); press_key(5); pulse_clear(); press_key(6);
    chk("s4_guess", guess, 16'h6FFF);
    chk("s4_count", 16'(digit_count), 16'd1);
    pulse_clear();

    // chord 2+3 ignored, then single 3
    ev_cnt = 0;
    @(negedge clk) key = 10'b00_0000_1100;
    repeat (20) @(negedge clk);
    key = '0;
    repeat (20) @(negedge clk);
    chk("s5_no_event", 16'(ev_cnt), 16'd0);
    chk("s5_guess_unchanged", guess, 16'hFFFF);
    press_key(3);
    chk("s5_guess", guess, 16'h3FFF);
    pulse_clear();

    // duplicate digit handling
    ev_cnt = 0;
    press_key(1); press_key(1); press_key(2); press_key(3); press_key(4);
    chk("s6_event_count", 16'(ev_cnt), 16'd5);
`ifdef KEYPAD_DUP_REJECT_EN
    chk("s6_guess_dup_reject", guess, 16'h1234);
`else
    chk("s6_guess_dup_kept", guess, 16'h1123);
`endif
    chk("s6_valid", 16'(guess_valid), 16'd1);
    @(negedge clk) guess_ready = 1'b1;
    @(negedge clk) guess_ready = 1'b0;

    // reset during debounce with key still held
    @(negedge clk) key = 10'b00_1000_0000;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("s7_no_early_event", 16'(key_event), 16'd0);
    @(posedge clk);
    #1 chk("s7_event_full_debounce", 16'(key_event), 16'd1);
    @(negedge clk) key = '0;
    repeat (20) @(negedge clk);
    chk("s7_guess", guess, 16'h7FFF);

    // reset during offer
    pulse_clear();
    press_key(1); press_key(2); press_key(3); press_key(4);
    chk("s8_valid_before", 16'(guess_valid), 16'd1);
    @(negedge clk) rst = 1'b0;
    #1 chk("s8_valid_rst", 16'(guess_valid), 16'd0);
    chk("s8_guess_rst", guess, 16'hFFFF);
    chk("s8_count_rst", 16'(digit_count), 16'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);

    done = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_guess_collector.md
Name: keypad_guess_collector

Overview:
- Upstream stage of the Bulls-and-Cows checker.
- Turns ten raw active-high digit buttons into debounced single-cycle key events and collects four digits into a packed 16-bit BCD guess.
- Offers the completed guess to the checker over a valid/ready handshake.
- Also exports a one-cycle key event and the current digit so the piezo and LCD stages can react to each press.

Parameters:
- DEBOUNCE_CYCLES, 50000, clock cycles a key vector must stay stable before it is accepted (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, 16, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- key  input  10  raw buttons, bit i = digit i, active high, asynchronous to clk
- clear  input  1  synchronous abort of the partial entry, active high
- guess  output  16  packed BCD guess; first-entered digit in [15:12]; unfilled slots read 4'hF
- guess_valid  output  1  complete guess offered
- guess_ready  input  1  checker accepts the guess
- digit_count  output  3  digits entered so far, 0..4
- key_event  output  1  one-cycle pulse per accepted digit
- key_digit  output  4  digit of the most recent accepted press (0..9)

Behaviour:
- Reset (rst=0, asynchronous):
  - guess=16'hFFFF, guess_valid=0, digit_count=0, key_event=0, key_digit=0.
  - Synchronizers, debounce counter and stable vector = 0.
  - FSM = COLLECT.
- Synchronizer:
  - 2-flop synchronizer on all 10 key bits.
- Debounce:
  - Candidate vector = synchronized key.
  - If the candidate differs from the previous cycle's candidate, the counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1, the stable vector loads the candidate.
- Press detection:
  - A press is accepted when the stable vector changes from all-zero to exactly one bit set.
  - Any multi-bit stable vector is ignored and produces no event.
  - After that, the vector must return to all-zero before the next press can be accepted.
  - Holding a key produces exactly one event.
- Latency: key_event is high for exactly 1 cycle, DEBOUNCE_CYCLES+3 clk edges after the raw key first becomes stable.
- key_digit: updates on the same cycle as key_event and holds until the next accepted press.
- FSM COLLECT:
  - An accepted press with digit_count<4 writes the digit into nibble slot (3-digit_count) and increments digit_count.
  - When the 4th digit is written, go to OFFER on the next cycle, with guess_valid=1.
- FSM OFFER:
  - guess and guess_valid are held stable.
  - Presses still pulse key_event and update key_digit, but do not alter guess or digit_count.
  - guess_valid & guess_ready, sampled at a rising edge, completes the transfer.
  - Next cycle: guess_valid=0, guess=16'hFFFF, digit_count=0, back to COLLECT.
  - guess_ready while guess_valid=0 has no effect.
- clear:
  - In COLLECT: guess=16'hFFFF, digit_count=0 next cycle.
  - In OFFER: ignored. The handshake must not be broken.
  - clear and a press in the same cycle: clear wins and the digit is dropped.
- Press and guess_ready in the same cycle in OFFER: the transfer completes and the press is not stored.
- Reset asserted mid-debounce or mid-OFFER: immediate return to the reset values; a key still held after reset release must go through a full debounce before it can be accepted.

Optional Feature:
- Macro: KEYPAD_DUP_REJECT_EN.
- When defined:
  - In COLLECT, a press whose digit already occupies a filled slot is not stored; digit_count is unchanged.
  - key_event still pulses, so the piezo still sounds.
  - Guesses always have 4 distinct digits.
- When undefined: duplicates are stored like any other digit.

Test Plan:
- All tests use DEBOUNCE_CYCLES=8.
- Press 1,2,3,4 (each held 20 cycles, released 20), guess_ready=1 -> guess=16'h1234; guess_valid high exactly 1 cycle; then guess=16'hFFFF, digit_count=0.
- Key bit 5 toggled every 3 cycles for 30 cycles, then held 20 -> exactly one key_event, key_digit=5, event 11 cycles after the last toggle.
- Press 9,8,7,6 with guess_ready=0 for 50 cycles, pressing 0 meanwhile -> guess holds 16'h9876 and guess_valid stays 1; key_event pulses, key_digit=0; raising ready ends the offer next cycle.
- Press 4,5, pulse clear, press 6 -> guess=16'h6FFF, digit_count=1.
- Keys 2 and 3 held together for 20 cycles -> no key_event and guess unchanged; release then press 3 -> guess=16'h3FFF.
- With KEYPAD_DUP_REJECT_EN defined: press 1,1,2,3,4 -> key_event count 5, guess=16'h1234. Without the macro: guess=16'h1123, guess_valid=1.
